// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-to-AXI bridge: FSM state encodings and
// fixed AXI attribute values.
package sram_axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_WAIT,
    R_RESP
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_B,
    W_RESP
  } wstate_t;

  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;
  localparam logic [3:0] ID_WRITE   = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/sram_axi_bridge.sv
// SRAM-like instruction/data ports to a single-beat AXI master.
// One read and one write may be outstanding at a time. Data reads wait
// behind an in-flight write; with BRIDGE_RAW_CHECK_EN defined they wait only
// when the word address matches the pending write.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  // instruction port (read-only)
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  rstate_t     rstate;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [3:0]  r_id;
  logic [31:0] r_rdata;

  wstate_t     wstate;
  logic [31:0] w_addr;
  logic [1:0]  w_size;
  logic [3:0]  w_strb;
  logic [31:0] w_data;
  logic        aw_done;
  logic        w_done;

  logic raw_hold;
  logic data_rd_acc;
  logic inst_rd_acc;
  logic data_wr_acc;
  logic rd_data_resp;

  // Inputs the bridge deliberately ignores (read-only inst port, IDs, responses).
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                           rid, rresp, rlast, bid, bresp};

`ifdef BRIDGE_RAW_CHECK_EN
  assign raw_hold = (wstate != W_IDLE) && (data_sram_addr[31:2] == w_addr[31:2]);
`else
  assign raw_hold = (wstate != W_IDLE);
`endif

  // Request arbitration: data reads beat inst reads; writes only need an idle write FSM.
  always_comb begin
    data_rd_acc = (rstate == R_IDLE) && data_sram_req && !data_sram_wr && !raw_hold;
    inst_rd_acc = (rstate == R_IDLE) && inst_sram_req && !data_rd_acc
                  && !(data_sram_req && !data_sram_wr);
    data_wr_acc = (wstate == W_IDLE) && data_sram_req && data_sram_wr;
    rd_data_resp = (rstate == R_RESP) && (r_id == ID_DATA);
  end

  assign inst_sram_addr_ok = inst_rd_acc;
  assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
  assign inst_sram_data_ok = (rstate == R_RESP) && (r_id == ID_INST);
  // The read response owns data_ok in a shared cycle; W_RESP waits it out.
  assign data_sram_data_ok = rd_data_resp || (wstate == W_RESP);
  assign inst_sram_rdata   = r_rdata;
  assign data_sram_rdata   = r_rdata;

  assign arid    = r_id;
  assign araddr  = r_addr;
  assign arlen   = '0;
  assign arsize  = {1'b0, r_size};
  assign arburst = BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = (rstate == R_AR);
  assign rready  = (rstate == R_WAIT);

  assign awid    = ID_WRITE;
  assign awaddr  = w_addr;
  assign awlen   = '0;
  assign awsize  = {1'b0, w_size};
  assign awburst = BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign awvalid = (wstate == W_REQ) && !aw_done;
  assign wid     = ID_WRITE;
  assign wdata   = w_data;
  assign wstrb   = w_strb;
  assign wlast   = 1'b1;
  assign wvalid  = (wstate == W_REQ) && !w_done;
  assign bready  = (wstate == W_B);

  // Read FSM: accept, issue AR, capture R beat, present one-cycle data_ok.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rstate  <= R_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_id    <= '0;
      r_rdata <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (data_rd_acc) begin
            r_addr <= data_sram_addr;
            r_size <= data_sram_size;
            r_id   <= ID_DATA;
            rstate <= R_AR;
          end else if (inst_rd_acc) begin
            r_addr <= inst_sram_addr;
            r_size <= inst_sram_size;
            r_id   <= ID_INST;
            rstate <= R_AR;
          end
        end
        R_AR:   if (arready) rstate <= R_WAIT;
        R_WAIT: begin
          if (rvalid) begin
            r_rdata <= rdata;
            rstate  <= R_RESP;
          end
        end
        R_RESP: rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Write FSM: AW and W handshake independently, then wait for B.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wstate  <= W_IDLE;
      w_addr  <= '0;
      w_size  <= '0;
      w_strb  <= '0;
      w_data  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (data_wr_acc) begin
            w_addr  <= data_sram_addr;
            w_size  <= data_sram_size;
            w_strb  <= data_sram_wstrb;
            w_data  <= data_sram_wdata;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wstate  <= W_REQ;
          end
        end
        W_REQ: begin
          if ((aw_done || awready) && (w_done || wready)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wstate  <= W_B;
          end else begin
            aw_done <= aw_done || awready;
            w_done  <= w_done || wready;
          end
        end
        W_B:    if (bvalid) wstate <= W_RESP;
        W_RESP: if (!rd_data_resp) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: a table of single read/write
// transactions plus hand-written arbitration, hazard and reset sequences.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        is_write;
    logic        is_data;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] wd;
    int unsigned d1;      // AR or AW ready delay (cycles)
    int unsigned d2;      // W ready delay (cycles)
    logic [31:0] rd;
    logic [2:0]  exp_size;
    logic [3:0]  exp_id;
  } vec_t;

  vec_t vecs [7];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic is_data, input logic [31:0] addr,
                         input logic [1:0] size, input int unsigned dly,
                         input logic [31:0] rd, input logic [2:0] esz,
                         input logic [3:0] eid);
    if (is_data) begin
      data_sram_req = 1'b1; data_sram_wr = 1'b0;
      data_sram_addr = addr; data_sram_size = size;
    end else begin
      inst_sram_req = 1'b1; inst_sram_addr = addr; inst_sram_size = size;
    end
    #1;
    chk("rd_addr_ok", is_data ? data_sram_addr_ok : inst_sram_addr_ok, 1);
    tick();
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    #1;
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, addr);
    chk("arsize", arsize, esz);
    chk("arid", arid, eid);
    chk("arlen_arburst", {arlen, arburst}, 10'h001);
    for (int unsigned i = 0; i < dly; i++) begin
      tick();
      chk("arvalid_hold", arvalid, 1);
      chk("araddr_hold", araddr, addr);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("rready", rready, 1);
    chk("arvalid_drop", arvalid, 0);
    rvalid = 1'b1; rdata = rd;
    tick();
    rvalid = 1'b0; rdata = '0;
    chk("rd_data_ok", is_data ? data_sram_data_ok : inst_sram_data_ok, 1);
    chk("rd_other_ok", is_data ? inst_sram_data_ok : data_sram_data_ok, 0);
    chk("rd_rdata", is_data ? data_sram_rdata : inst_sram_rdata, rd);
    tick();
    chk("rd_data_ok_once", {inst_sram_data_ok, data_sram_data_ok}, 0);
    chk("rd_rdata_hold", inst_sram_rdata, rd);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] size,
                          input logic [3:0] strb, input logic [31:0] wd,
                          input int unsigned awd, input int unsigned wdl,
                          input logic [2:0] esz);
    int unsigned n;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = addr;
    data_sram_size = size; data_sram_wstrb = strb; data_sram_wdata = wd;
    #1;
    chk("wr_addr_ok", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 1'b0; data_sram_wr = 1'b0;
    #1;
    chk("awaddr", awaddr, addr);
    chk("awsize", awsize, esz);
    chk("wdata", wdata, wd);
    chk("wstrb", wstrb, strb);
    chk("awid_wid_wlast", {awid, wid, wlast}, 9'h023);
    n = (awd > wdl) ? awd : wdl;
    for (int unsigned c = 0; c <= n; c++) begin
      awready = (c == awd);
      wready  = (c == wdl);
      #1;
      chk("awvalid", awvalid, (c <= awd) ? 1 : 0);
      chk("wvalid", wvalid, (c <= wdl) ? 1 : 0);
      tick();
    end
    awready = 1'b0; wready = 1'b0;
    chk("bready", bready, 1);
    chk("aw_w_idle", {awvalid, wvalid}, 0);
    chk("wr_no_early_ok", data_sram_data_ok, 0);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("wr_data_ok", data_sram_data_ok, 1);
    tick();
    chk("wr_data_ok_once", data_sram_data_ok, 0);
    chk("bready_drop", bready, 0);
  endtask

  initial begin
    logic exp_raw;
    vecs[0] = '{1'b0, 1'b0, 32'h1C00_0000, 2'd2, 4'h0, 32'h0, 2, 0, 32'hDEAD_BEEF, 3'b010, 4'd0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0003, 2'd0, 4'h0, 32'h0, 0, 0, 32'h0000_00A5, 3'b000, 4'd1};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_1002, 2'd1, 4'h0, 32'h0, 1, 0, 32'hBEEF_0000, 3'b001, 4'd1};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0100, 2'd2, 4'b0011, 32'h1234_5678, 2, 0, 32'h0, 3'b010, 4'd1};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0044, 2'd0, 4'b0100, 32'h00AB_0000, 0, 1, 32'h0, 3'b000, 4'd1};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0080, 2'd2, 4'hF, 32'hCAFE_F00D, 0, 0, 32'h0, 3'b010, 4'd1};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 2'd2, 4'h0, 32'h0, 0, 0, 32'h0000_0000, 3'b010, 4'd0};

    resetn = 1'b0;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_addr = 0;
    inst_sram_wstrb = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_addr = 0;
    data_sram_wstrb = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    tick(); tick();
    resetn = 1'b1;

    chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    chk("rst_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    chk("rst_rdata", data_sram_rdata, 0);
    chk("rst_addr_ok_noreq", {inst_sram_addr_ok, data_sram_addr_ok}, 0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_write)
        do_write(vecs[i].addr, vecs[i].size, vecs[i].strb, vecs[i].wd,
                 vecs[i].d1, vecs[i].d2, vecs[i].exp_size);
      else
        do_read(vecs[i].is_data, vecs[i].addr, vecs[i].size, vecs[i].d1,
                vecs[i].rd, vecs[i].exp_size, vecs[i].exp_id);
    end

    // Simultaneous inst and data read: data wins, inst waits for R_RESP to finish.
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0040; inst_sram_size = 2;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_0800; data_sram_size = 2;
    #1;
    chk("arb_data_ok", data_sram_addr_ok, 1);
    chk("arb_inst_wait", inst_sram_addr_ok, 0);
    tick();
    data_sram_req = 0;
    #1;
    chk("arb_arid_data", arid, 1);
    chk("arb_inst_busy", inst_sram_addr_ok, 0);
    arready = 1; tick(); arready = 0;
    rvalid = 1; rdata = 32'h1111_2222; tick(); rvalid = 0;
    chk("arb_data_resp", {inst_sram_data_ok, data_sram_data_ok}, 2'b01);
    chk("arb_inst_in_resp", inst_sram_addr_ok, 0);
    tick();
    chk("arb_inst_now", inst_sram_addr_ok, 1);
    tick();
    inst_sram_req = 0;
    #1;
    chk("arb_arid_inst", arid, 0);
    chk("arb_araddr_inst", araddr, 32'h1C00_0040);
    arready = 1; tick(); arready = 0;
    rvalid = 1; rdata = 32'h3333_4444; tick(); rvalid = 0;
    chk("arb_inst_resp", {inst_sram_data_ok, data_sram_data_ok}, 2'b10);
    chk("arb_inst_rdata", inst_sram_rdata, 32'h3333_4444);
    tick();

    // Read-after-write hazard on word 0x200.
`ifdef BRIDGE_RAW_CHECK_EN
    exp_raw = 1'b1;
`else
    exp_raw = 1'b0;
`endif
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h200;
    data_sram_size = 2; data_sram_wstrb = 4'hF; data_sram_wdata = 32'h5A5A_5A5A;
    tick();
    data_sram_wr = 0; data_sram_addr = 32'h204;
    #1;
    chk("raw_other_word", data_sram_addr_ok, {31'd0, exp_raw});
    data_sram_addr = 32'h200;
    #1;
    chk("raw_same_word", data_sram_addr_ok, 0);
    awready = 1; wready = 1; tick(); awready = 0; wready = 0;
    chk("raw_in_b", data_sram_addr_ok, 0);
    bvalid = 1; tick(); bvalid = 0;
    chk("raw_w_resp_ok", data_sram_data_ok, 1);
    chk("raw_in_resp", data_sram_addr_ok, 0);
    tick();
    chk("raw_released", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 0;
    #1;
    chk("raw_araddr", araddr, 32'h200);
    arready = 1; tick(); arready = 0;
    rvalid = 1; rdata = 32'h5A5A_5A5A; tick(); rvalid = 0;
    chk("raw_rd_ok", data_sram_data_ok, 1);
    chk("raw_rdata", data_sram_rdata, 32'h5A5A_5A5A);
    tick();

    // Reset while waiting on R: the read is abandoned.
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0100; inst_sram_size = 2;
    tick();
    inst_sram_req = 0;
    arready = 1; tick(); arready = 0;
    chk("rst_mid_rready", rready, 1);
    resetn = 0;
    tick();
    resetn = 1;
    chk("rst_mid_rready_low", rready, 0);
    chk("rst_mid_no_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    rvalid = 1; rdata = 32'h7777_7777; tick(); rvalid = 0;
    chk("rst_mid_stray_r", {inst_sram_data_ok, data_sram_data_ok}, 0);
    chk("rst_mid_rdata", inst_sram_rdata, 0);
    do_read(1'b0, 32'h1C00_0200, 2'd2, 1, 32'h0BAD_CAFE, 3'b010, 4'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0x00000001 expected 0x00000000");
    $fatal(1);
  end

endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 SHALL have ports: clk input 1, core clock; resetn input 1, reset, synchronous, active-low.
REQ-002 SHALL have inst port: inst_sram_req in 1, inst_sram_wr in 1 (ignored; read-only), inst_sram_size in 2, inst_sram_addr in 32, inst_sram_wstrb in 4 (ignored), inst_sram_wdata in 32 (ignored), inst_sram_addr_ok out 1, inst_sram_data_ok out 1, inst_sram_rdata out 32.
REQ-003 SHALL have data port: data_sram_req/wr/size/addr/wstrb/wdata in, same widths; data_sram_addr_ok, data_sram_data_ok, data_sram_rdata[31:0] out.
REQ-004 SHALL have AXI read master: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid out; arready in; rid 4, rdata 32, rresp 2, rlast 1, rvalid in; rready out.
REQ-005 SHALL have AXI write master: awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid out, awready in; wid 4, wdata 32, wstrb 4, wlast 1, wvalid out, wready in; bid 4, bresp 2, bvalid in, bready out.
REQ-006 SHALL drive constants: arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, awid=wid=1, wlast=1; arsize/awsize = {1'b0, size}.

Function
REQ-007 Read FSM SHALL use states R_IDLE, R_AR, R_WAIT, R_RESP; one read outstanding total.
REQ-008 In R_IDLE, a read request SHALL be accepted with a combinational addr_ok pulse; data read beats inst read when both pending.
REQ-009 On acceptance SHALL latch addr, size, arid (inst=0, data=1) and enter R_AR with arvalid=1 next cycle.
REQ-010 arvalid SHALL hold with stable fields until arready; then R_WAIT with rready=1.
REQ-011 On rvalid&rready SHALL register rdata, enter R_RESP; in R_RESP the port selected by latched id SHALL see data_ok=1 for exactly one cycle, then R_IDLE.
REQ-012 rdata outputs SHALL hold last returned value until next return; rresp/bresp ignored.
REQ-013 Write FSM SHALL use states W_IDLE, W_REQ, W_B, W_RESP; writes only from data port; one write outstanding.
REQ-014 In W_IDLE a data write SHALL be accepted with addr_ok pulse, latching addr, size, wstrb, wdata; W_REQ asserts awvalid and wvalid together next cycle.
REQ-015 awvalid and wvalid SHALL drop independently on their own handshakes (aw_done/w_done flags); both done -> W_B with bready=1.
REQ-016 On bvalid SHALL enter W_RESP; data_sram_data_ok=1 for one cycle, then W_IDLE.
REQ-017 Data port SHALL get at most one addr_ok per cycle; if a data write and a pending read response share a cycle, read data_ok in R_RESP takes priority and W_RESP stalls one cycle.
REQ-018 Inst and data data_ok SHALL never be asserted for a transaction not yet accepted; addr_ok SHALL be 0 when req=0.

Reset
REQ-019 On resetn=0 at clk edge: both FSMs idle, arvalid/awvalid/wvalid/rready/bready=0, all data_ok=0, latched fields and rdata=0.
REQ-020 Reset mid-transaction SHALL abandon it; no data_ok issued afterward for it.

Configuration
REQ-021 Macro BRIDGE_RAW_CHECK_EN defined: a data read SHALL be held off (no addr_ok) only while write FSM is non-idle and word address addr[31:2] matches latched write address.
REQ-022 Macro undefined: a data read SHALL be held off whenever write FSM is non-idle; inst reads unaffected in both cases.

Structure
REQ-023 Shared package SHALL hold read/write state encodings, AXI burst/ID constants (ID_INST=0, ID_DATA=1, BURST_INCR).
REQ-024 Single module; no sub-module required; both FSMs one-hot or binary, implementer's choice.

Verification
REQ-025 Inst read 0x1C000000, arready after 2 cycles, rdata=0xDEADBEEF -> one araddr=0x1C000000 arid=0, then inst_data_ok with 0xDEADBEEF.
REQ-026 Inst and data read same cycle -> data addr_ok first, arid=1; inst accepted after data R_RESP.
REQ-027 Data write addr 0x100 wstrb 4'b0011 wdata 0x12345678, wready before awready -> wvalid drops first, single B, one data_ok.
REQ-028 Write 0x200 outstanding + read 0x200 -> read stalled until W_RESP; with BRIDGE_RAW_CHECK_EN read 0x204 proceeds immediately.
REQ-029 resetn low during R_WAIT -> rready=0 next cycle, no data_ok; fresh read afterward completes normally.
REQ-030 Byte read size=0 addr 0x3 -> arsize=3'b000, araddr=0x3.
